// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arbiter_pkg;

    localparam int ADDR_W = 32;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ERR
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [31:0]       wdata;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester, response and memory-side signals of the arbiter
interface dmem_arbiter_if #(
    parameter int AW = 32
) ();
    logic          req0_valid;
    logic          req0_ready;
    logic [AW-1:0] req0_addr;
    logic          req0_we;
    logic [31:0]   req0_wdata;
    logic          resp0_valid;
    logic [31:0]   resp0_rdata;
    logic          resp0_err;

    logic          req1_valid;
    logic          req1_ready;
    logic [AW-1:0] req1_addr;
    logic          req1_we;
    logic [31:0]   req1_wdata;
    logic          resp1_valid;
    logic [31:0]   resp1_rdata;
    logic          resp1_err;

    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   mem_rdata;

    modport slave (
        input  req0_valid, req0_addr, req0_we, req0_wdata,
        input  req1_valid, req1_addr, req1_we, req1_wdata,
        input  mem_rdata,
        output req0_ready, resp0_valid, resp0_rdata, resp0_err,
        output req1_ready, resp1_valid, resp1_rdata, resp1_err,
        output mem_addr, mem_wdata, mem_read, mem_write
    );

    modport master (
        output req0_valid, req0_addr, req0_we, req0_wdata,
        output req1_valid, req1_addr, req1_we, req1_wdata,
        output mem_rdata,
        input  req0_ready, resp0_valid, resp0_rdata, resp0_err,
        input  req1_ready, resp1_valid, resp1_rdata, resp1_err,
        input  mem_addr, mem_wdata, mem_read, mem_write
    );

endinterface

// File: rtl/dmem_arb_grant.sv
// rtl/dmem_arb_grant.sv - two-port grant selector; DMEM_ARB_RR_EN selects round-robin over fixed priority
module dmem_arb_grant
    import dmem_arbiter_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
`ifdef DMEM_ARB_RR_EN
    input  logic last_owner,
`endif
    output logic grant,
    output logic grant_idx
);

    always_comb begin
        grant     = valid0 | valid1;
        grant_idx = PORT0;
`ifdef DMEM_ARB_RR_EN
        // On a tie the port that was not served last wins.
        if (valid0 && valid1) begin
            grant_idx = ~last_owner;
        end else if (valid1) begin
            grant_idx = PORT1;
        end
`else
        if (!valid0 && valid1) begin
            grant_idx = PORT1;
        end
`endif
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one data memory between two requesters (DMEM_ARB_RR_EN: round-robin grant)
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW      = ADDR_W,
    parameter int DEPTH   = 1000,
    parameter int MEM_LAT = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_arbiter_if.slave   bus
);

    localparam int            CW        = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 4);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    req_t          lat_q;
    logic          owner_q;

    logic          grant;
    logic          grant_idx;
    logic          accept;
    logic [AW-1:0] sel_addr;
    req_t          sel_req;
    logic          addr_bad;

    logic          ready0;
    logic          ready1;
    logic          mem_read;
    logic          mem_write;

    logic          resp0_valid_q;
    logic          resp1_valid_q;
    resp_t         resp0_q;
    resp_t         resp1_q;

`ifdef DMEM_ARB_RR_EN
    logic          last_owner_q;
`endif

    dmem_arb_grant u_grant (
        .valid0     (bus.req0_valid),
        .valid1     (bus.req1_valid),
`ifdef DMEM_ARB_RR_EN
        .last_owner (last_owner_q),
`endif
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // Reset overrides any request seen in the same cycle.
    assign accept   = (state_q == IDLE) && grant && !reset;
    assign sel_addr = (grant_idx == PORT1) ? bus.req1_addr : bus.req0_addr;
    assign addr_bad = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD);

    always_comb begin
        sel_req       = '0;
        sel_req.addr  = ADDR_W'(sel_addr);
        sel_req.we    = (grant_idx == PORT1) ? bus.req1_we    : bus.req0_we;
        sel_req.wdata = (grant_idx == PORT1) ? bus.req1_wdata : bus.req0_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ready0    = 1'b0;
        ready1    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ready0  = (grant_idx == PORT0);
                    ready1  = (grant_idx == PORT1);
                    state_d = addr_bad ? ERR : ACCESS;
                end
            end
            ACCESS: begin
                mem_read  = ~lat_q.we;
                mem_write = lat_q.we;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            lat_q         <= '0;
            owner_q       <= PORT0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp0_q       <= '0;
            resp1_q       <= '0;
`ifdef DMEM_ARB_RR_EN
            last_owner_q  <= PORT0;
`endif
        end else begin
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            if (accept) begin
                lat_q   <= sel_req;
                owner_q <= grant_idx;
                cnt_q   <= CW'(MEM_LAT - 1);
`ifdef DMEM_ARB_RR_EN
                last_owner_q <= grant_idx;
`endif
            end
            if (state_q == ACCESS) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else if (owner_q == PORT0) begin
                    resp0_valid_q <= 1'b1;
                    resp0_q.rdata <= lat_q.we ? 32'h0 : bus.mem_rdata;
                    resp0_q.err   <= 1'b0;
                end else begin
                    resp1_valid_q <= 1'b1;
                    resp1_q.rdata <= lat_q.we ? 32'h0 : bus.mem_rdata;
                    resp1_q.err   <= 1'b0;
                end
            end
            if (state_q == ERR) begin
                if (owner_q == PORT0) begin
                    resp0_valid_q <= 1'b1;
                    resp0_q       <= '{rdata: 32'h0, err: 1'b1};
                end else begin
                    resp1_valid_q <= 1'b1;
                    resp1_q       <= '{rdata: 32'h0, err: 1'b1};
                end
            end
        end
    end

    assign bus.req0_ready  = ready0;
    assign bus.req1_ready  = ready1;
    assign bus.resp0_valid = resp0_valid_q;
    assign bus.resp0_rdata = resp0_q.rdata;
    assign bus.resp0_err   = resp0_q.err;
    assign bus.resp1_valid = resp1_valid_q;
    assign bus.resp1_rdata = resp1_q.rdata;
    assign bus.resp1_err   = resp1_q.err;
    assign bus.mem_addr    = AW'(lat_q.addr);
    assign bus.mem_wdata   = lat_q.wdata;
    assign bus.mem_read    = mem_read;
    assign bus.mem_write   = mem_write;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter (DMEM_ARB_RR_EN selects round-robin expectations)
module tb_dmem_arbiter;

    localparam int MEM_LAT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(32)) bus ();

    dmem_arbiter #(.AW(32), .DEPTH(1000), .MEM_LAT(MEM_LAT)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Big-endian byte memory standing in for the data RAM.
    logic [7:0] mem [0:1023];
    wire  [9:0] ma = bus.mem_addr[9:0];

    always @(posedge clk) begin
        if (bus.mem_write) begin
            mem[ma]         <= bus.mem_wdata[31:24];
            mem[ma + 10'd1] <= bus.mem_wdata[23:16];
            mem[ma + 10'd2] <= bus.mem_wdata[15:8];
            mem[ma + 10'd3] <= bus.mem_wdata[7:0];
        end
    end

    assign bus.mem_rdata = bus.mem_read ?
        {mem[ma], mem[ma + 10'd1], mem[ma + 10'd2], mem[ma + 10'd3]} : 32'bz;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   got_order[$];
    int   last_acc[2];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   mr_cnt   = 0;
    int   mw_cnt   = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: event occurred, none required", name);
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (bus.mem_read)  mr_cnt++;
        if (bus.mem_write) mw_cnt++;
        if (bus.req0_ready || bus.req1_ready)
            chk("single_ready", {31'b0, bus.req0_ready & bus.req1_ready}, 32'd0);
        if (bus.resp0_valid) begin
            if (exp_q0.size() == 0) fail("resp0_unexpected");
            else begin
                me = exp_q0.pop_front();
                chk("resp0_rdata", bus.resp0_rdata, me.rdata);
                chk("resp0_err", {31'b0, bus.resp0_err}, {31'b0, me.err});
                chk("resp0_latency", 32'(cyc - me.acc), me.err ? 32'd2 : 32'(MEM_LAT + 1));
            end
        end
        if (bus.resp1_valid) begin
            if (exp_q1.size() == 0) fail("resp1_unexpected");
            else begin
                me = exp_q1.pop_front();
                chk("resp1_rdata", bus.resp1_rdata, me.rdata);
                chk("resp1_err", {31'b0, bus.resp1_err}, {31'b0, me.err});
                chk("resp1_latency", 32'(cyc - me.acc), me.err ? 32'd2 : 32'(MEM_LAT + 1));
            end
        end
    end

    // Presents one request, waits for ready, then registers the expected response.
    task automatic drive(input int p, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata, input logic [31:0] erd, input logic eerr);
        exp_t e;
        int   n;
        logic rdy;
        if (p == 0) begin
            bus.req0_addr = addr; bus.req0_we = we; bus.req0_wdata = wdata; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_addr = addr; bus.req1_we = we; bus.req1_wdata = wdata; bus.req1_valid = 1'b1;
        end
        n = 0;
        forever begin
            @(negedge clk);
            rdy = (p == 0) ? bus.req0_ready : bus.req1_ready;
            if (rdy) break;
            n++;
            if (n > 200) break;
        end
        if (!rdy) begin
            fail($sformatf("ready_timeout_p%0d", p));
        end else begin
            e.rdata = erd; e.err = eerr; e.acc = cyc;
            if (p == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
            got_order.push_back(p);
            last_acc[p] = cyc;
        end
        @(posedge clk); #1;
        if (p == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail("idle_timeout");
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        got_order.delete();
    endtask

    task automatic check_order(input string name, input int want0, input int want1, input int want2,
                               input int want3, input int want4, input int want5, input int len);
        int want[6];
        want = '{want0, want1, want2, want3, want4, want5};
        chk({name, "_len"}, 32'(got_order.size()), 32'(len));
        for (int i = 0; i < len && i < got_order.size(); i++)
            chk($sformatf("%s_%0d", name, i), 32'(got_order[i]), 32'(want[i]));
    endtask

    int mr0;
    int mw0;
    int n_wait;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        {mem[32], mem[33], mem[34], mem[35]}     = 32'hA1B2C3D4;
        {mem[36], mem[37], mem[38], mem[39]}     = 32'h0BADF00D;
        {mem[40], mem[41], mem[42], mem[43]}     = 32'h12345678;
        {mem[996], mem[997], mem[998], mem[999]} = 32'hCAFEBABE;

        bus.req0_valid = 1'b1; bus.req0_addr = 32'h10; bus.req0_we = 1'b0; bus.req0_wdata = 32'h0;
        bus.req1_valid = 1'b0; bus.req1_addr = 32'h0;  bus.req1_we = 1'b0; bus.req1_wdata = 32'h0;
        reset = 1'b1;

        // Request together with reset: reset wins, no ready.
        @(negedge clk);
        chk("reset_ready0", {31'b0, bus.req0_ready}, 32'd0);
        chk("reset_outputs", {28'b0, bus.resp0_valid, bus.resp1_valid, bus.mem_read, bus.mem_write}, 32'd0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        reset = 1'b0;

        // Store then load on port 0.
        mw0 = mw_cnt;
        drive(0, 32'h10, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0);
        wait_idle();
        chk("store_write_cycles", 32'(mw_cnt - mw0), 32'(MEM_LAT));
        mr0 = mr_cnt;
        drive(0, 32'h10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
        wait_idle();
        chk("load_read_cycles", 32'(mr_cnt - mr0), 32'(MEM_LAT));

        // Misaligned load on port 1.
        mr0 = mr_cnt;
        drive(1, 32'h22, 1'b0, 32'h0, 32'h0, 1'b1);
        wait_idle();
        chk("misaligned_no_read", 32'(mr_cnt - mr0), 32'd0);

        // Range boundary.
        drive(0, 32'h3E8, 1'b0, 32'h0, 32'h0, 1'b1);
        drive(0, 32'h3E4, 1'b0, 32'h0, 32'hCAFEBABE, 1'b0);
        wait_idle();

        // Simultaneous requests.
        do_reset();
        fork
            drive(0, 32'h20, 1'b0, 32'h0, 32'hA1B2C3D4, 1'b0);
            drive(1, 32'h24, 1'b0, 32'h0, 32'h0BADF00D, 1'b0);
        join
        wait_idle();
`ifdef DMEM_ARB_RR_EN
        check_order("tie_order", 1, 0, 0, 0, 0, 0, 2);
        chk("tie_second_accept", 32'(last_acc[0] - last_acc[1]), 32'(MEM_LAT + 1));
`else
        check_order("tie_order", 0, 1, 0, 0, 0, 0, 2);
        chk("tie_second_accept", 32'(last_acc[1] - last_acc[0]), 32'(MEM_LAT + 1));
`endif

        // Port 0 streams loads while port 1 waits.
        do_reset();
        fork
            begin
                drive(0, 32'h20, 1'b0, 32'h0, 32'hA1B2C3D4, 1'b0);
                drive(0, 32'h24, 1'b0, 32'h0, 32'h0BADF00D, 1'b0);
                drive(0, 32'h20, 1'b0, 32'h0, 32'hA1B2C3D4, 1'b0);
                drive(0, 32'h24, 1'b0, 32'h0, 32'h0BADF00D, 1'b0);
            end
            begin
                drive(1, 32'h28, 1'b0, 32'h0, 32'h12345678, 1'b0);
                drive(1, 32'h28, 1'b0, 32'h0, 32'h12345678, 1'b0);
            end
        join
        wait_idle();
`ifdef DMEM_ARB_RR_EN
        check_order("stream_order", 1, 0, 1, 0, 0, 0, 6);
`else
        check_order("stream_order", 0, 0, 0, 0, 1, 1, 6);
`endif

        // Reset in the second access cycle of a store: dropped, no response.
        bus.req0_addr = 32'h30; bus.req0_we = 1'b1; bus.req0_wdata = 32'h55AA55AA; bus.req0_valid = 1'b1;
        n_wait = 0;
        @(negedge clk);
        while (!bus.req0_ready && n_wait < 50) begin
            @(negedge clk);
            n_wait++;
        end
        chk("abort_store_accepted", {31'b0, bus.req0_ready}, 32'd1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_still_writing", {31'b0, bus.mem_write}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_strobes_ready", {28'b0, bus.mem_read, bus.mem_write, bus.req0_ready, bus.req1_ready}, 32'd0);
        chk("abort_resp", {30'b0, bus.resp0_valid, bus.resp1_valid}, 32'd0);
        chk("abort_mem_addr", bus.mem_addr, 32'd0);
        chk("abort_mem_wdata", bus.mem_wdata, 32'd0);
        chk("abort_rdata", bus.resp0_rdata | bus.resp1_rdata, 32'd0);
        repeat (5) @(negedge clk);

        chk("scoreboard_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
